// File: rtl/adc_pkg.sv
// Shared types, frame constants and the offset-binary to PCM conversion for
// the MCP3202 stereo capture path.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    PUBLISH
  } adc_state_e;

  localparam int ADC_FRAME_BITS = 17;
  localparam int ADC_NULL_EDGE  = 5;
  localparam int ADC_CMD_BITS   = 4;

  // Offset-binary 12-bit code to signed 16-bit PCM, left-justified.
  function automatic logic [15:0] adc_to_pcm(input logic [11:0] raw);
    return {~raw[11], raw[10:0], 4'b0000};
  endfunction

endpackage

// File: rtl/adc_dc_block.sv
// Per-channel DC-removal filter: a leaky running mean subtracted from each
// sample. Only instantiated when ADC_DC_BLOCK_EN is defined.
module adc_dc_block #(
  parameter int DC_SHIFT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] pcm,
  output logic [15:0] dout
);

  localparam int AW = 17 + DC_SHIFT;

  logic signed [AW-1:0] acc;
  logic        [16:0]   mean;
  logic        [17:0]   diff;
  logic        [15:0]   diff_sat;

  always_comb begin
    mean = 17'(acc >>> DC_SHIFT);
    diff = {pcm[15], pcm[15], pcm} - {mean[16], mean};
    // Clamp to the 16-bit range when the top three bits disagree.
    if (diff[17:15] == 3'b000 || diff[17:15] == 3'b111) diff_sat = diff[15:0];
    else if (diff[17])                                  diff_sat = 16'h8000;
    else                                                diff_sat = 16'h7fff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      dout <= '0;
    end else if (en) begin
      acc  <= acc + {{(AW-18){diff[17]}}, diff};
      dout <= diff_sat;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic two-channel MCP3202 SPI capture producing a stereo PCM pair.
// Optional DC removal on both channels when ADC_DC_BLOCK_EN is defined.
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int SCLK_HALF  = 7,
  parameter int CS_GAP     = 14,
  parameter int SAMPLE_DIV = 563,
  parameter int DC_SHIFT   = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             adc_clk,
  output logic             adc_cs,
  output logic             adc_mosi,
  input  logic             adc_miso,
  output logic [1:0][15:0] audio_sample_word,
  output logic             sample_valid,
  output logic             busy
);

  localparam int PW     = $clog2(SAMPLE_DIV);
  localparam int HW     = $clog2(SCLK_HALF);
  localparam int GW     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int HALVES = 2 * ADC_FRAME_BITS;

  if (SCLK_HALF < 3 || CS_GAP < 1 || DC_SHIFT < 1 ||
      SAMPLE_DIV < 2 * (HALVES * SCLK_HALF + CS_GAP) + 3) begin : g_param_check
    $error("adc_spi_sampler: parameter constraints violated");
  end

  adc_state_e       state, state_nx;
  logic [PW-1:0]    period_cnt;
  logic [HW-1:0]    half_cnt;
  logic [5:0]       half_idx;
  logic [GW-1:0]    gap_cnt;
  logic             chan;
  logic             miso_meta, miso_sync;
  logic [1:0][11:0] raw;
  logic [3:0]       cmd;
  logic [4:0]       bit_idx;
  logic             tick, half_end, frame_end, gap_end, publish;

  assign tick      = (period_cnt == PW'(SAMPLE_DIV - 1));
  assign half_end  = (half_cnt == HW'(SCLK_HALF - 1));
  assign frame_end = half_end && (half_idx == 6'(HALVES - 1));
  assign gap_end   = (gap_cnt == GW'(CS_GAP - 1));
  assign bit_idx   = half_idx[5:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) period_cnt <= '0;
    else if (tick) period_cnt <= '0;
    else           period_cnt <= period_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    adc_cs   = 1'b1;
    adc_clk  = 1'b0;
    adc_mosi = 1'b0;
    busy     = 1'b0;
    publish  = 1'b0;
    cmd      = {1'b1, chan, 2'b11};  // bit0 start, bit1 SGL, bit2 ODD, bit3 MSBF
    case (state)
      IDLE:    if (tick) state_nx = SHIFT;
      SHIFT: begin
        adc_cs   = 1'b0;
        adc_clk  = half_idx[0];
        adc_mosi = (bit_idx < 5'(ADC_CMD_BITS)) && cmd[bit_idx[1:0]];
        busy     = 1'b1;
        if (frame_end) state_nx = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (gap_end) state_nx = chan ? PUBLISH : SHIFT;
      end
      PUBLISH: begin
        publish  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SPI timing counters; both rest at zero outside their own state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      half_idx <= '0;
      gap_cnt  <= '0;
      chan     <= 1'b0;
    end else begin
      if (state != SHIFT) begin
        half_cnt <= '0;
        half_idx <= '0;
      end else if (half_end) begin
        half_cnt <= '0;
        half_idx <= half_idx + 1'b1;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == GAP && gap_end) chan <= ~chan;
    end
  end

  // MISO is sampled at the end of each high phase; edges up to the null bit are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      raw       <= '0;
    end else begin
      miso_meta <= adc_miso;
      miso_sync <= miso_meta;
      if (state == SHIFT && half_idx[0] && half_end && bit_idx >= 5'(ADC_NULL_EDGE))
        raw[chan] <= {raw[chan][10:0], miso_sync};
    end
  end

  // sample_valid is a one-cycle strobe with no back-pressure; audio_sample_word
  // is stable while it is high and holds until the next strobe.
`ifdef ADC_DC_BLOCK_EN
  for (genvar i = 0; i < 2; i++) begin : g_dc
    logic [15:0] pcm;
    assign pcm = adc_to_pcm(raw[i]);
    adc_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (publish),
      .pcm     (pcm),
      .dout    (audio_sample_word[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sample_valid <= 1'b0;
    else          sample_valid <= publish;
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_sample_word <= '0;
    end else if (state == GAP && gap_end && chan) begin
      audio_sample_word[0] <= adc_to_pcm(raw[0]);
      audio_sample_word[1] <= adc_to_pcm(raw[1]);
    end
  end

  assign sample_valid = publish;
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: MCP3202 pin model, SPI timing monitor and a
// sample scoreboard fed from a table of fixed cases and random conversions.
module tb_adc_spi_sampler;

  localparam int SCLK_HALF  = 7;
  localparam int CS_GAP     = 14;
  localparam int SAMPLE_DIV = 563;
  localparam int DC_SHIFT   = 10;
  localparam int FRAME_LEN  = 34 * SCLK_HALF;
`ifdef ADC_DC_BLOCK_EN
  localparam int LAT = 2 * (FRAME_LEN + CS_GAP) + 2;
`else
  localparam int LAT = 2 * (FRAME_LEN + CS_GAP) + 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             adc_clk, adc_cs, adc_mosi;
  logic             adc_miso = 1'b0;
  logic [1:0][15:0] audio_sample_word;
  logic             sample_valid, busy;

  adc_spi_sampler #(
    .SCLK_HALF  (SCLK_HALF),
    .CS_GAP     (CS_GAP),
    .SAMPLE_DIV (SAMPLE_DIV),
    .DC_SHIFT   (DC_SHIFT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .adc_clk           (adc_clk),
    .adc_cs            (adc_cs),
    .adc_mosi          (adc_mosi),
    .adc_miso          (adc_miso),
    .audio_sample_word (audio_sample_word),
    .sample_valid      (sample_valid),
    .busy              (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] adc_raw [2];
  logic        null_bit;
  logic [31:0] exp_q[$];
  logic [31:0] last_word = '0;
  longint      acc_m [2];

  function automatic logic [15:0] ref_pcm(input int code);
    int v;
    v = (code - 2048) * 16;
    return 16'(v);
  endfunction

  function automatic logic [15:0] ref_out(input int ch, input logic [15:0] pcm);
`ifdef ADC_DC_BLOCK_EN
    longint p, mean, d;
    p    = longint'($signed(pcm));
    mean = acc_m[ch] >>> DC_SHIFT;
    d    = p - mean;
    acc_m[ch] = acc_m[ch] + d;
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    return d[15:0];
`else
    if (ch > 1) return 16'h0;
    return pcm;
`endif
  endfunction

  function automatic logic exp_mosi(input int k, input int ch);
    if (k == 1 || k == 2 || k == 4) return 1'b1;
    if (k == 3) return ch[0];
    return 1'b0;
  endfunction

  // Bit the ADC presents for rising edge k of a frame.
  function automatic logic model_bit(input int k, input int ch);
    if (k == 5) return null_bit;
    if (k >= 6 && k <= 17) return adc_raw[ch][17-k];
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- pin model + monitor ----------------
  int   fall_cnt = 0, rise_k = 0, fall_k = 0, cur_ch = 0, n_valid = 0;
  int   fall_cyc = 0, ch0_fall = 0, cs_rise_cyc = 0;
  logic prev_cs = 1'b1, prev_clk = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
  logic [31:0] exp_word;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      cyc = 0; fall_cnt = 0; rise_k = 0; fall_k = 0;
      prev_cs = 1'b1; prev_clk = 1'b0; prev_valid = 1'b0; prev_busy = 1'b0;
      adc_miso = 1'b0;
    end else begin
      cyc++;
      if (!adc_cs && prev_cs) begin
        if (fall_cnt == 0) check("first_cs_fall_cycle", cyc, SAMPLE_DIV);
        if (fall_cnt % 2 == 0) begin
          ch0_fall = cyc;
          check("busy_at_cs_fall", busy, 1'b1);
        end else begin
          check("ch1_cs_gap", cyc - cs_rise_cyc, CS_GAP);
        end
        cur_ch   = fall_cnt % 2;
        fall_cyc = cyc;
        rise_k   = 0;
        fall_k   = 0;
        adc_miso = model_bit(1, cur_ch);
        fall_cnt++;
      end
      if (adc_clk && !prev_clk) begin
        rise_k++;
        check("sclk_rise_cycle", cyc - fall_cyc, (2 * rise_k - 1) * SCLK_HALF);
        check("mosi_bit", adc_mosi, exp_mosi(rise_k, cur_ch));
      end
      if (!adc_clk && prev_clk) begin
        fall_k++;
        check("sclk_fall_cycle", cyc - fall_cyc, 2 * fall_k * SCLK_HALF);
        adc_miso = model_bit(rise_k + 1, cur_ch);
      end
      if (adc_cs && !prev_cs) begin
        check("cs_rise_cycle", cyc - fall_cyc, FRAME_LEN);
        check("sclk_pulses", rise_k, 17);
        cs_rise_cyc = cyc;
      end
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", sample_valid, 1'b0);
        end else begin
          exp_word = exp_q.pop_front();
          check("sample_word", audio_sample_word, exp_word);
          last_word = exp_word;
          check("valid_latency", cyc - ch0_fall, LAT - 1);
          check("busy_at_valid", busy, 1'b0);
`ifndef ADC_DC_BLOCK_EN
          check("busy_before_valid", prev_busy, 1'b1);
`endif
        end
        n_valid++;
      end
      if (prev_valid) check("valid_one_cycle", sample_valid, 1'b0);
      prev_cs    = adc_cs;
      prev_clk   = adc_clk;
      prev_valid = sample_valid;
      prev_busy  = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input logic [11:0] r0, input logic [11:0] r1, input logic nb,
                           input logic [15:0] pcm0, input logic [15:0] pcm1);
    int target, waited;
    adc_raw[0] = r0;
    adc_raw[1] = r1;
    null_bit   = nb;
    check("word_hold", audio_sample_word, last_word);
    exp_q.push_back({ref_out(1, pcm1), ref_out(0, pcm0)});
    target = n_valid + 1;
    waited = 0;
    while (n_valid < target && waited < 3 * SAMPLE_DIV) begin
      @(posedge clk); #2;
      waited++;
    end
    if (n_valid < target) begin
      check("valid_timeout", n_valid, target);
      exp_q.delete();
    end
    repeat ($urandom_range(1, 40)) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    adc_cs, 1'b1);
    check({tag, "_sclk"},  adc_clk, 1'b0);
    check({tag, "_mosi"},  adc_mosi, 1'b0);
    check({tag, "_word"},  audio_sample_word, 32'h0);
    check({tag, "_valid"}, sample_valid, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n   = 1'b1;
    last_word = '0;
    acc_m[0]  = 0;
    acc_m[1]  = 0;
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [11:0] raw0;
    logic [11:0] raw1;
    logic        nb;
    logic [15:0] pcm0;
    logic [15:0] pcm1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int target, waited;
    logic [11:0] r0, r1;

    vecs[0] = '{12'hFFF, 12'h000, 1'b0, 16'h7FF0, 16'h8000};
    vecs[1] = '{12'h800, 12'h800, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{12'h123, 12'h800, 1'b1, 16'h9230, 16'h0000};
    vecs[3] = '{12'h000, 12'hFFF, 1'b1, 16'h8000, 16'h7FF0};
    vecs[4] = '{12'h7FF, 12'h801, 1'b0, 16'hFFF0, 16'h0010};
    adc_raw[0] = '0;
    adc_raw[1] = '0;
    null_bit   = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    release_reset();

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].raw0, vecs[i].raw1, vecs[i].nb, vecs[i].pcm0, vecs[i].pcm1);

    for (int i = 0; i < 10; i++) begin
      r0 = 12'($urandom_range(0, 4095));
      r1 = 12'($urandom_range(0, 4095));
      run_frame(r0, r1, 1'($urandom_range(0, 1)), ref_pcm(r0), ref_pcm(r1));
    end

    // Abort during the ch1 frame: nothing may be published.
    adc_raw[0] = 12'h5A5;
    adc_raw[1] = 12'hA5A;
    target = fall_cnt + 2;
    waited = 0;
    while (fall_cnt < target && waited < 2 * SAMPLE_DIV) begin
      @(posedge clk); #2;
      waited++;
    end
    check("abort_reached_ch1", fall_cnt, target);
    repeat (5 * SCLK_HALF) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge clk);
    release_reset();

    for (int i = 0; i < 2; i++) begin
      r0 = 12'($urandom_range(0, 4095));
      r1 = 12'($urandom_range(0, 4095));
      run_frame(r0, r1, 1'($urandom_range(0, 1)), ref_pcm(r0), ref_pcm(r1));
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
